mem_port_arbiter: RTL and testbench

- Shares the single memory port (proc2mem_*/mem2proc_*) among NUM_REQ requesters: the K/V/Q vector loaders (reads) and the O drain (writes).
- Round-robin grant, outstanding-load tag tracking, routing of returned data to the requester that issued the tag.
- Sits between the phase-sequencing memory controller logic and the external memory model.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ load/store requesters.
// Tracks outstanding load tags and routes returned data back to the issuing requester.
module mem_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int TAG_W           = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [NUM_REQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                proc2mem_command,
  output logic [ADDR_W-1:0]         proc2mem_addr,
  output logic [DATA_W-1:0]         proc2mem_data,
  input  logic [TAG_W-1:0]          mem2proc_transaction_tag,
  input  logic [DATA_W-1:0]         mem2proc_data,
  input  logic [TAG_W-1:0]          mem2proc_data_tag,
  output logic                      busy,
  output logic                      err
);
  localparam int TBL   = 1 << TAG_W;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  logic [TBL-1:0]     tbl_vld_reg, tbl_vld_next;
  logic [PTR_W-1:0]   tbl_owner_reg [TBL];
  logic [PTR_W-1:0]   tbl_owner_next [TBL];
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [NUM_REQ-1:0] rsp_vld_reg, rsp_vld_next;
  logic [DATA_W-1:0]  rsp_data_reg, rsp_data_next;
  logic               err_reg, err_next;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic               can_load, accept, ld_accept, ld_dup, ld_inc;
  logic               ret_any, ret_hit, ret_stale;
  logic [TAG_W-1:0]   acc_tag, ret_tag;

  assign can_load = count_reg < CNT_W'(MAX_OUTSTANDING);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = req_vld[gi] & (req_wr[gi] | can_load);
    end
  endgenerate

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign acc_tag   = mem2proc_transaction_tag;
  assign ret_tag   = mem2proc_data_tag;
  assign accept    = win_found && (acc_tag != '0);
  assign ld_accept = accept && !req_wr[win_idx];
  assign ret_any   = ret_tag != '0;
  assign ret_hit   = ret_any && tbl_vld_reg[ret_tag];
  assign ret_stale = ret_any && !tbl_vld_reg[ret_tag];
  // A same-cycle return of the accept tag frees the entry before it is reused.
  assign ld_dup    = ld_accept && tbl_vld_reg[acc_tag] && !(ret_hit && (ret_tag == acc_tag));
  assign ld_inc    = ld_accept && !ld_dup;

  assign req_rdy = accept ? (NUM_REQ'(1) << win_idx) : '0;

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (win_found) begin
      proc2mem_command = req_wr[win_idx] ? MEM_STORE : MEM_LOAD;
      proc2mem_addr    = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      proc2mem_data    = req_data[int'(win_idx)*DATA_W +: DATA_W];
    end
  end

  generate
    for (gi = 0; gi < TBL; gi++) begin : g_tbl
      logic set_e, clr_e;
      assign set_e              = ld_accept && (acc_tag == TAG_W'(gi));
      assign clr_e              = ret_hit && (ret_tag == TAG_W'(gi));
      assign tbl_vld_next[gi]   = set_e | (tbl_vld_reg[gi] & ~clr_e);
      assign tbl_owner_next[gi] = set_e ? win_idx : tbl_owner_reg[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (ld_inc && !ret_hit)
      count_next = count_reg + CNT_W'(1);
    else if (ret_hit && !ld_inc)
      count_next = count_reg - CNT_W'(1);
    rr_ptr_next = rr_ptr_reg;
    if (accept)
      rr_ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    rsp_vld_next  = ret_hit ? (NUM_REQ'(1) << tbl_owner_reg[ret_tag]) : '0;
    rsp_data_next = ret_hit ? mem2proc_data : rsp_data_reg;
    err_next      = err_reg | ret_stale | ld_dup;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_vld_reg   <= '0;
      tbl_owner_reg <= '{default: '0};
      count_reg     <= '0;
      rr_ptr_reg    <= '0;
      rsp_vld_reg   <= '0;
      rsp_data_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      tbl_vld_reg   <= tbl_vld_next;
      tbl_owner_reg <= tbl_owner_next;
      count_reg     <= count_next;
      rr_ptr_reg    <= rr_ptr_next;
      rsp_vld_reg   <= rsp_vld_next;
      rsp_data_reg  <= rsp_data_next;
      err_reg       <= err_next;
    end
  end

  assign rsp_vld  = rsp_vld_reg;
  assign rsp_data = rsp_data_reg;
  assign busy     = count_reg != '0;
  assign err      = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a tag-table reference model predicts grants
// and responses; a separate monitor pops expected responses as the DUT presents them.
module tb_mem_port_arbiter;
  localparam int NR = 4, TW = 4, AW = 32, DW = 64, MAXO = 8, NT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_vld = '0, req_wr = '0, req_rdy, rsp_vld;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [DW-1:0]    rsp_data, proc2mem_data, mem2proc_data = '0;
  logic [1:0]       proc2mem_command;
  logic [AW-1:0]    proc2mem_addr;
  logic [TW-1:0]    mem2proc_transaction_tag = '0, mem2proc_data_tag = '0;
  logic             busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
    .req_data(req_data), .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_transaction_tag(mem2proc_transaction_tag),
    .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
    .busy(busy), .err(err)
  );

  typedef struct { int due; logic [NR-1:0] vld; logic [DW-1:0] data; } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_owner[NT];
  int m_cnt, m_rr;
  bit m_err;
  logic [AW-1:0] ta[NR];
  logic [DW-1:0] td[NR];
  int held_tags[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) m_owner[t] = -1;
    m_cnt = 0; m_rr = 0; m_err = 1'b0;
    exp_q.delete();
  endfunction

  function automatic int model_winner(input logic [NR-1:0] vld, input logic [NR-1:0] wr);
    for (int k = 0; k < NR; k++) begin
      int i = (m_rr + k) % NR;
      if (vld[i] && (wr[i] || m_cnt < MAXO)) return i;
    end
    return -1;
  endfunction

  function automatic int pick_free(input int avoid);
    int c[$];
    for (int t = 1; t < NT; t++) if (m_owner[t] < 0 && t != avoid) c.push_back(t);
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  function automatic int pick_owned();
    int c[$];
    for (int t = 1; t < NT; t++) if (m_owner[t] >= 0) c.push_back(t);
    if (c.size() == 0) return 0;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  // One cycle: acc_sel -1 = memory picks a tag, 0 = reject, >0 = that tag.
  task automatic step(input logic [NR-1:0] vld, input logic [NR-1:0] wr, input int acc_sel,
                      input int rtag, input logic [DW-1:0] rdata);
    int w, tag;
    logic [1:0] e_cmd;
    #1;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = ta[i];
      req_data[i*DW +: DW] = td[i];
    end
    req_vld = vld; req_wr = wr;
    w = model_winner(vld, wr);
    tag = 0;
    if (w >= 0) begin
      if (acc_sel < 0) tag = wr[w] ? int'($urandom_range(1, NT - 1)) : pick_free(rtag);
      else tag = acc_sel;
    end
    mem2proc_transaction_tag = TW'(tag);
    mem2proc_data_tag        = TW'(rtag);
    mem2proc_data            = rdata;
    @(negedge clk);
    check("busy", busy, m_cnt != 0);
    check("err", err, m_err);
    e_cmd = (w < 0) ? 2'd0 : (wr[w] ? 2'd2 : 2'd1);
    check("command", proc2mem_command, e_cmd);
    check("addr", proc2mem_addr, (w < 0) ? '0 : ta[w]);
    check("wdata", proc2mem_data, (w < 0) ? '0 : td[w]);
    check("req_rdy", req_rdy, (w >= 0 && tag != 0) ? NR'(1 << w) : '0);
    if (rtag != 0) begin
      if (m_owner[rtag] >= 0) begin
        exp_q.push_back('{due: cyc + 1, vld: NR'(1 << m_owner[rtag]), data: rdata});
        m_owner[rtag] = -1;
        m_cnt--;
      end else m_err = 1'b1;
    end
    if (w >= 0 && tag != 0) begin
      $display("cycle %0d: grant req %0d %s addr %h tag %0d", cyc, w, wr[w] ? "store" : "load", ta[w], tag);
      m_rr = (w + 1) % NR;
      if (!wr[w]) begin
        held_tags.push_back(tag);
        if (m_owner[tag] >= 0) m_err = 1'b1;
        else m_cnt++;
        m_owner[tag] = w;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, -1, 0, '0);
  endtask

  task automatic drain();
    for (int t = 1; t < NT; t++)
      if (m_owner[t] >= 0) step('0, '0, -1, t, {$urandom, $urandom});
    idle(1);
  endtask

  // Reset lands mid-cycle, so the checks below also prove it is asynchronous.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    req_vld = '0; req_wr = '0;
    mem2proc_transaction_tag = '0; mem2proc_data_tag = '0;
    model_reset();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rsp_vld", rsp_vld, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_command", proc2mem_command, 2'd0);
    check("rst_req_rdy", req_rdy, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        mon_e = exp_q.pop_front();
        $display("cycle %0d: response to %b data %h", cyc, rsp_vld, rsp_data);
        check("rsp_vld", rsp_vld, mon_e.vld);
        check("rsp_data", rsp_data, mon_e.data);
      end else if (rsp_vld !== '0) begin
        check("rsp_vld_idle", rsp_vld, '0);
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < NR; i++) begin ta[i] = $urandom; td[i] = {$urandom, $urandom}; end
    do_reset();

    // single load
    ta[0] = 32'h1000;
    step(4'b0001, 4'b0000, 3, 0, '0);
    idle(4);
    step('0, '0, -1, 3, 64'hDEADBEEF);
    idle(2);

    // round robin from a fresh pointer
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b0000, -1, 0, '0);
    drain();

    // backpressure on Q
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, 0, 0, '0);
    step(4'b0100, 4'b0000, -1, 0, '0);
    drain();

    // out-of-order returns
    step(4'b0001, 4'b0000, 1, 0, '0);
    step(4'b0010, 4'b0000, 2, 0, '0);
    step('0, '0, -1, 2, 64'h2222_0000_AAAA_0002);
    step('0, '0, -1, 1, 64'h1111_0000_BBBB_0001);
    idle(2);

    // outstanding limit
    for (int i = 0; i < MAXO; i++) step(4'b0001, 4'b0000, -1, 0, '0);
    step(4'b0001, 4'b0000, -1, 0, '0);
    step(4'b1001, 4'b1000, -1, 0, '0);
    t = pick_owned();
    step(4'b0001, 4'b0000, -1, t, 64'h0123_4567_89AB_CDEF);
    step(4'b0001, 4'b0000, -1, 0, '0);
    drain();

    // same-tag return and reissue in one cycle
    step(4'b0001, 4'b0000, 5, 0, '0);
    step(4'b0010, 4'b0000, 5, 5, 64'h5555_5555_5555_5555);
    idle(1);
    drain();

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int acc, rt;
      for (int i = 0; i < NR; i++) begin ta[i] = $urandom; td[i] = {$urandom, $urandom}; end
      acc = ($urandom_range(0, 3) == 0) ? 0 : -1;
      rt  = ($urandom_range(0, 9) < 4) ? pick_owned() : 0;
      step(NR'($urandom), NR'($urandom), acc, rt, {$urandom, $urandom});
    end
    drain();

    // stale return, then duplicate accept
    step('0, '0, -1, 5, 64'hBAD0_BAD0_BAD0_BAD0);
    step(4'b0100, 4'b0000, 7, 0, '0);
    step(4'b1000, 4'b0000, 7, 0, '0);
    drain();

    // reset with three loads in flight; their late returns are stale
    do_reset();
    held_tags.delete();
    for (int i = 0; i < 3; i++) step(4'b0111, 4'b0000, -1, 0, '0);
    do_reset();
    for (int i = 0; i < 3; i++) step('0, '0, -1, held_tags[i], {$urandom, $urandom});
    idle(2);

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
